data_ram_responder: RTL and testbench

//  Responder for the core's data-RAM port (ram_en/ram_write_en/ram_addr/ram_write_data -> ram_read_data).

---
 rtl/data_ram_responder_if.sv | 27 ++
 rtl/data_ram_responder.sv | 123 ++++++++++++
 tb/tb_data_ram_responder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/data_ram_responder_if.sv
// Data-RAM port of the core plus the req/ack peripheral bus served by data_ram_responder.
// The slave modport is the responder; the master modport is the core/peripheral side.
interface data_ram_responder_if;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic        stall;
  logic        bus_req;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  modport slave (
    input  ram_en, ram_write_en, ram_addr, ram_write_data, bus_rdata, bus_ack,
    output ram_read_data, stall, bus_req, bus_we, bus_addr, bus_wdata, bus_err
  );

  modport master (
    output ram_en, ram_write_en, ram_addr, ram_write_data, bus_rdata, bus_ack,
    input  ram_read_data, stall, bus_req, bus_we, bus_addr, bus_wdata, bus_err
  );
endinterface

// File: rtl/data_ram_responder.sv
// Zero-wait local SRAM for the core's data port, with an MMIO window forwarded to a
// req/ack peripheral bus; the core is stalled while a peripheral access is outstanding.
module data_ram_responder #(
  parameter int unsigned MEM_ADDR_W   = 10,
  parameter logic [3:0]  MMIO_NIBBLE  = 4'hB,
  parameter int unsigned TIMEOUT      = 16,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input logic                  i_clk,
  input logic                  i_rst,
  data_ram_responder_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << MEM_ADDR_W;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [31:0]           r_bus_addr;
  logic [3:0]            r_bus_we;
  logic [31:0]           r_bus_wdata;
  logic [31:0]           r_cap;
  logic                  r_err;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_mmio_hit;
  logic                  w_local_hit;
  logic                  w_local_wr;
  logic                  w_tmo;
  logic [MEM_ADDR_W-1:0] w_idx;
  logic [31:0]           w_rdata;
  logic                  w_stall;

  assign w_mmio_hit  = bus.ram_en & (bus.ram_addr[31:28] == MMIO_NIBBLE);
  assign w_local_hit = bus.ram_en & ~w_mmio_hit;
  assign w_local_wr  = w_local_hit & (|bus.ram_write_en);
  assign w_idx       = bus.ram_addr[MEM_ADDR_W+1:2];
  assign w_tmo       = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Byte-lane SRAM writes; contents deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (w_local_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.ram_write_en[i]) r_mem[w_idx][8*i +: 8] <= bus.ram_write_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state plus the combinational core-facing outputs.
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_rdata = 32'h0;
    case (r_state)
      S_IDLE: begin
        // Gated by reset so the core is released while reset is held.
        w_stall = w_mmio_hit & i_rst;
        if (w_mmio_hit) w_next = S_REQ;
      end
      S_REQ: begin
        w_stall = 1'b1;
        if (bus.bus_ack || w_tmo) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (r_state == S_DONE)                           w_rdata = r_cap;
    else if (w_local_hit && bus.ram_write_en == 4'h0) w_rdata = r_mem[w_idx];
  end

  // Peripheral request registers, timeout counter and captured response.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt       <= '0;
      r_bus_addr  <= 32'h0;
      r_bus_we    <= 4'h0;
      r_bus_wdata <= 32'h0;
      r_cap       <= 32'h0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_mmio_hit) begin
            r_bus_addr  <= bus.ram_addr;
            r_bus_we    <= bus.ram_write_en;
            r_bus_wdata <= bus.ram_write_data;
            r_cnt       <= '0;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (bus.bus_ack) begin
            r_cap <= (|r_bus_we) ? 32'h0 : bus.bus_rdata;
          end else if (w_tmo) begin
            r_cap <= TIMEOUT_DATA;
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ram_read_data = w_rdata;
  assign bus.stall         = w_stall;
  assign bus.bus_req       = (r_state == S_REQ);
  assign bus.bus_we        = r_bus_we;
  assign bus.bus_addr      = r_bus_addr;
  assign bus.bus_wdata     = r_bus_wdata;
  assign bus.bus_err       = r_err;

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench for data_ram_responder: local SRAM vector table plus hand-written
// MMIO sequences (read, write, timeout, ack/timeout race, reset mid-request, back-to-back).
module tb_data_ram_responder;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  data_ram_responder_if bus_if ();

  data_ram_responder #(
    .MEM_ADDR_W  (10),
    .MMIO_NIBBLE (4'hB),
    .TIMEOUT     (4),
    .TIMEOUT_DATA(32'hDEADBEEF)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } lvec_t;

  lvec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_core(input logic en, input logic [3:0] we, input logic [31:0] addr,
                            input logic [31:0] wdata);
    bus_if.ram_en         = en;
    bus_if.ram_write_en   = we;
    bus_if.ram_addr       = addr;
    bus_if.ram_write_data = wdata;
  endtask

  // One local-port cycle: data must be served in the same cycle with no stall.
  task automatic local_op(input string nm, input logic en, input logic [3:0] we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd);
    @(negedge clk);
    drive_core(en, we, addr, wdata);
    #1;
    chk({nm, ".rdata"}, bus_if.ram_read_data, exp_rd);
    chk({nm, ".stall"}, 32'(bus_if.stall), 32'h0);
    chk({nm, ".req"},   32'(bus_if.bus_req), 32'h0);
  endtask

  // One MMIO access; ack_at = REQ cycle (1-based) in which ack is driven, 0 = never.
  task automatic mmio(input string nm, input logic [31:0] addr, input logic [3:0] we,
                      input logic [31:0] wdata, input int ack_at, input logic [31:0] ack_data,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_reqs);
    int stalls;
    int reqs;
    bit done;
    stalls = 0;
    reqs   = 0;
    done   = 1'b0;
    @(negedge clk);
    drive_core(1'b1, we, addr, wdata);
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      bus_if.bus_ack = 1'b0;
      if (bus_if.stall) stalls++;
      if (bus_if.bus_req) begin
        reqs++;
        chk({nm, ".bus_addr"},  bus_if.bus_addr, addr);
        chk({nm, ".bus_we"},    32'(bus_if.bus_we), 32'(we));
        chk({nm, ".bus_wdata"}, bus_if.bus_wdata, wdata);
        bus_if.bus_ack   = (reqs == ack_at);
        bus_if.bus_rdata = ack_data;
      end else if (!bus_if.stall && c > 0) begin
        done = 1'b1;
        chk({nm, ".done_rdata"}, bus_if.ram_read_data, exp_rd);
        chk({nm, ".done_err"},   32'(bus_if.bus_err), 32'(exp_err));
      end
      if (!done) @(negedge clk);
    end
    bus_if.bus_ack = 1'b0;
    chk({nm, ".completed"}, 32'(done), 32'h1);
    chk({nm, ".req_cycles"}, 32'(reqs), 32'(exp_reqs));
    chk({nm, ".stall_cycles"}, 32'(stalls), 32'(exp_reqs + 1));
    @(negedge clk);
    drive_core(1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    chk({nm, ".err_after"},   32'(bus_if.bus_err), 32'h0);
    chk({nm, ".stall_after"}, 32'(bus_if.stall), 32'h0);
    chk({nm, ".req_after"},   32'(bus_if.bus_req), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    vecs[0]  = '{1'b1, 4'hF, 32'h0000_0100, 32'h1122_3344, 32'h0};
    vecs[1]  = '{1'b1, 4'h0, 32'h0000_0100, 32'h0,         32'h1122_3344};
    vecs[2]  = '{1'b1, 4'h2, 32'h0000_0100, 32'h0000_AA00, 32'h0};
    vecs[3]  = '{1'b1, 4'h0, 32'h0000_0100, 32'h0,         32'h1122_AA44};
    vecs[4]  = '{1'b0, 4'h0, 32'h0000_0100, 32'h0,         32'h0};
    vecs[5]  = '{1'b1, 4'hF, 32'h0000_0104, 32'h0102_0304, 32'h0};
    vecs[6]  = '{1'b1, 4'h9, 32'h0000_0104, 32'hA1B2_C3D4, 32'h0};
    vecs[7]  = '{1'b1, 4'h0, 32'h0000_0104, 32'h0,         32'hA102_03D4};
    vecs[8]  = '{1'b1, 4'h0, 32'h0000_1103, 32'h0,         32'h1122_AA44};
    vecs[9]  = '{1'b1, 4'hF, 32'hA000_0200, 32'hFEED_FACE, 32'h0};
    vecs[10] = '{1'b0, 4'hF, 32'h0000_0200, 32'h0,         32'h0};
    vecs[11] = '{1'b1, 4'h0, 32'h0000_0200, 32'h0,         32'hFEED_FACE};

    rst = 1'b0;
    drive_core(1'b0, 4'h0, 32'h0, 32'h0);
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.stall",     32'(bus_if.stall), 32'h0);
    chk("rst.req",       32'(bus_if.bus_req), 32'h0);
    chk("rst.err",       32'(bus_if.bus_err), 32'h0);
    chk("rst.bus_we",    32'(bus_if.bus_we), 32'h0);
    chk("rst.bus_addr",  bus_if.bus_addr, 32'h0);
    chk("rst.bus_wdata", bus_if.bus_wdata, 32'h0);
    chk("rst.rdata",     bus_if.ram_read_data, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      local_op($sformatf("local%0d", i), vecs[i].en, vecs[i].we, vecs[i].addr,
               vecs[i].wdata, vecs[i].exp_rd);
    end

    mmio("mmio_rd",  32'hB000_0010, 4'h0, 32'h0,         3, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 3);
    mmio("mmio_wr",  32'hB000_0004, 4'hF, 32'h5A5A_5A5A, 2, 32'h1234_5678, 32'h0,         1'b0, 2);
    mmio("timeout",  32'hB000_0008, 4'h0, 32'h0,         0, 32'h0,         32'hDEAD_BEEF, 1'b1, 4);
    mmio("ack_race", 32'hB000_000C, 4'h0, 32'h0,         4, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 4);

    // Reset asserted in the second REQ cycle, with the core still presenting the access.
    @(negedge clk);
    drive_core(1'b1, 4'h0, 32'hB000_0020, 32'h0);
    @(negedge clk);
    #1;
    chk("rstreq.req1", 32'(bus_if.bus_req), 32'h1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rstreq.req",      32'(bus_if.bus_req), 32'h0);
    chk("rstreq.stall",    32'(bus_if.stall), 32'h0);
    chk("rstreq.bus_addr", bus_if.bus_addr, 32'h0);
    drive_core(1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'h7777_7777;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    #1;
    chk("late_ack.req",   32'(bus_if.bus_req), 32'h0);
    chk("late_ack.stall", 32'(bus_if.stall), 32'h0);
    chk("late_ack.err",   32'(bus_if.bus_err), 32'h0);
    chk("late_ack.rdata", bus_if.ram_read_data, 32'h0);
    mmio("post_rst", 32'hB000_0030, 4'h0, 32'h0, 1, 32'h0000_0042, 32'h0000_0042, 1'b0, 1);

    // Back-to-back: MMIO read, local read, MMIO read.
    mmio("b2b_a", 32'hB000_0040, 4'h0, 32'h0, 1, 32'hAAAA_0001, 32'hAAAA_0001, 1'b0, 1);
    local_op("b2b_local", 1'b1, 4'h0, 32'h0000_0100, 32'h0, 32'h1122_AA44);
    mmio("b2b_b", 32'hB000_0044, 4'h0, 32'h0, 2, 32'hBBBB_0002, 32'hBBBB_0002, 1'b0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
